branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
Parametrised, registered successor to the combinational branch/jump resolvers. It owns the program counter and accepts one control-flow op per handshake. It resolves BEQ/BNE/BGT/BGTE/BLT/BLE/J/JAL/JR/RET with signed compares and keeps a circular return-address stack (RAS). On every taken redirect it emits a redirect pulse and flushes the front end for a fixed number of cycles. It sits between decode and fetch; fetch reads `pc`.

Parameters:
XLEN, 32, datapath and PC width (word-addressed PC, sequential step +1)
OFF_W, 16, branch offset width, sign-extended to XLEN
TGT_W, 26, jump target field width, sign-extended to XLEN
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
FLUSH_CYCLES, 1, cycles in_ready is held low after a redirect (>=1)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  op presented
in_ready  out  1  unit can accept; transfer when in_valid && in_ready
op  in  4  operation code (package enum)
rs_a  in  XLEN  first operand, signed; JR target; RET fallback target
rs_b  in  XLEN  second operand, signed
offset  in  OFF_W  branch offset
target  in  TGT_W  J/JAL target field
stall  in  1  external hold; forces in_ready low
pc  out  XLEN  current PC, registered
redirect  out  1  one-cycle pulse the cycle after a taken transfer is accepted
link_valid  out  1  one-cycle pulse with link_addr after an accepted JAL
link_addr  out  XLEN  return address (accepted pc + 1)
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_underflow  out  1  one-cycle pulse: RET accepted with RAS empty

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=RUN, RAS count=0, all pulses 0, link_addr=0. in_ready=1 once rst=1 and stall=0.
- in_ready = (state==RUN) && !stall, combinational. Accept = in_valid && in_ready.
- No accept: pc holds. NOP accepted: pc <= pc+1.
- Branches (BEQ ==, BNE !=, BGT >, BGTE >=, BLT <, BLE <=; signed XLEN compare of rs_a vs rs_b):
  - taken: pc <= pc + sext(offset) + 1
  - not taken: pc <= pc+1, no redirect.
- J: pc <= sext(target).
- JAL: pc <= sext(target); push pc+1 onto RAS; link_valid=1 and link_addr=pc+1 next cycle.
- JR: pc <= rs_a; RAS untouched.
- RET: pc <= RAS top and pop. If the RAS is empty: pc <= rs_a, ras_underflow pulses, count stays 0.
- Illegal op codes: treated as NOP.
- Taken transfer (taken branch, J, JAL, JR, RET): redirect=1 for exactly the next cycle, state RUN->FLUSH. FLUSH counts FLUSH_CYCLES cycles with in_ready=0, then returns to RUN. Latency from accept to new pc visible: 1 cycle.
- Stall: asserted during FLUSH, it does not extend the flush count. Asserted in RUN, it only blocks acceptance.
- RAS:
  - Circular buffer with top pointer and count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH, ras_full stays 1.
  - Push and pop never coincide, since one op per accept.
- Arithmetic: all PC math is modulo 2^XLEN; pc = 2^XLEN-1 plus 1 wraps to 0. offset and target are sign-extended from their MSB.
- Reset mid-FLUSH or with a non-empty RAS: immediately returns to reset values; RAS contents are discarded (count=0).

Decomposition:
- Shared package branch_pkg holds:
  - op enum: NOP=0, BEQ=1, BNE=2, BGT=3, BGTE=4, BLT=5, BLE=6, J=7, JAL=8, JR=9, RET=10
  - state enum: RUN, FLUSH
  - a sext helper function
- Single natural sub-module: ras_stack (parameters XLEN, RAS_DEPTH; ports push, pop, push_data, top, empty, full).

Test Plan:
- Reset then NOP accepted 3 times (RESET_PC=0) -> pc 1,2,3; redirect never asserted; in_ready=1 throughout.
- pc=10, BGT, rs_a=-1, rs_b=-5, offset=0xFFFC -> pc=7 next cycle; redirect pulse; in_ready=0 for 1 cycle, then 1.
- Same BGT with rs_a=-5, rs_b=-1 -> pc=11, no redirect, in_ready stays 1.
- pc=20, JAL target=100 -> pc=100, link_valid with link_addr=21; RET with rs_a=0 -> pc=21, ras_empty=1 afterwards.
- Five JALs from pc values 0,1,2,3,4 with RAS_DEPTH=4 -> ras_full=1; four RETs return 5,4,3,2; fifth RET with rs_a=77 -> pc=77, ras_underflow pulse.
- pc=0xFFFFFFFF NOP -> pc=0. rst asserted during FLUSH -> pc=RESET_PC, in_ready=1 the first cycle after release.

Source files
------------

// File: rtl/branch_pkg.sv
// ============================================================================
// Module : branch_pkg
// Brief  : Shared op/state encodings and sign-extension helper for the
//          branch/PC unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_BEQ  = 4'd1,
        OP_BNE  = 4'd2,
        OP_BGT  = 4'd3,
        OP_BGTE = 4'd4,
        OP_BLT  = 4'd5,
        OP_BLE  = 4'd6,
        OP_J    = 4'd7,
        OP_JAL  = 4'd8,
        OP_JR   = 4'd9,
        OP_RET  = 4'd10
    } op_e;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int unsigned C_SEXT_MAX_W = 64;

    // Sign-extends the low i_w bits of i_val to the full 64-bit width.
    function automatic logic [C_SEXT_MAX_W-1:0] sext(
        input logic [C_SEXT_MAX_W-1:0] i_val,
        input int unsigned             i_w
    );
        logic [6:0] w_sh;
        w_sh = 7'(C_SEXT_MAX_W - i_w);
        return C_SEXT_MAX_W'($signed(i_val << w_sh) >>> w_sh);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_pc_unit_ras.sv
// ============================================================================
// Module : ras_stack
// Brief  : Circular return-address stack; a push when full overwrites the
//          oldest entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_push_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_top_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_push_ptr;

    assign w_push_ptr = r_top_ptr + PTR_W'(1);
    assign o_top      = r_mem[r_top_ptr];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(RAS_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top_ptr <= '0;
            r_count   <= '0;
        end else if (i_push) begin
            r_top_ptr <= w_push_ptr;
            if (!o_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_top_ptr <= r_top_ptr - PTR_W'(1);
            r_count   <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_push_ptr] <= i_push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_pc_unit.sv
// ============================================================================
// Module : branch_pc_unit
// Brief  : Registered program counter with branch/jump resolution, return
//          address stack and post-redirect front-end flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          OFF_W        = 16,
    parameter int          TGT_W        = 26,
    parameter int          RAS_DEPTH    = 4,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] RESET_PC     = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_op,
    input  logic [XLEN-1:0]  i_rs_a,
    input  logic [XLEN-1:0]  i_rs_b,
    input  logic [OFF_W-1:0] i_offset,
    input  logic [TGT_W-1:0] i_target,
    input  logic             i_stall,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_redirect,
    output logic             o_link_valid,
    output logic [XLEN-1:0]  o_link_addr,
    output logic             o_ras_empty,
    output logic             o_ras_full,
    output logic             o_ras_underflow
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_plus1;
    logic [XLEN-1:0]  w_off_ext;
    logic [XLEN-1:0]  w_tgt_ext;
    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_ras_top;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic             w_accept;
    logic             w_is_br;
    logic             w_cond;
    logic             w_taken;
    logic             w_push;
    logic             w_pop;
    logic             w_underflow;
    logic             w_link;

    assign o_in_ready = (r_state == ST_RUN) && !i_stall;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_pc_plus1 = r_pc + XLEN'(1);
    assign w_off_ext  = XLEN'(sext(C_SEXT_MAX_W'(i_offset), OFF_W));
    assign w_tgt_ext  = XLEN'(sext(C_SEXT_MAX_W'(i_target), TGT_W));

    always_comb begin
        w_is_br     = 1'b0;
        w_cond      = 1'b0;
        w_taken     = 1'b0;
        w_next_pc   = w_pc_plus1;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        w_link      = 1'b0;
        case (op_e'(i_op))
            OP_BEQ:  begin w_is_br = 1'b1; w_cond = (i_rs_a == i_rs_b); end
            OP_BNE:  begin w_is_br = 1'b1; w_cond = (i_rs_a != i_rs_b); end
            OP_BGT:  begin w_is_br = 1'b1; w_cond = ($signed(i_rs_a) >  $signed(i_rs_b)); end
            OP_BGTE: begin w_is_br = 1'b1; w_cond = ($signed(i_rs_a) >= $signed(i_rs_b)); end
            OP_BLT:  begin w_is_br = 1'b1; w_cond = ($signed(i_rs_a) <  $signed(i_rs_b)); end
            OP_BLE:  begin w_is_br = 1'b1; w_cond = ($signed(i_rs_a) <= $signed(i_rs_b)); end
            OP_J: begin
                w_taken   = 1'b1;
                w_next_pc = w_tgt_ext;
            end
            OP_JAL: begin
                w_taken   = 1'b1;
                w_next_pc = w_tgt_ext;
                w_push    = 1'b1;
                w_link    = 1'b1;
            end
            OP_JR: begin
                w_taken   = 1'b1;
                w_next_pc = i_rs_a;
            end
            OP_RET: begin
                w_taken = 1'b1;
                if (w_ras_empty) begin
                    w_next_pc   = i_rs_a;
                    w_underflow = 1'b1;
                end else begin
                    w_next_pc = w_ras_top;
                    w_pop     = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_is_br && w_cond) begin
            w_taken   = 1'b1;
            w_next_pc = r_pc + w_off_ext + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Stall is deliberately ignored here so it cannot stretch the flush window.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_taken) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= XLEN'(RESET_PC);
            o_redirect      <= 1'b0;
            o_link_valid    <= 1'b0;
            o_link_addr     <= '0;
            o_ras_underflow <= 1'b0;
        end else begin
            o_redirect      <= w_accept && w_taken;
            o_link_valid    <= w_accept && w_link;
            o_ras_underflow <= w_accept && w_underflow;
            if (w_accept) begin
                r_pc <= w_next_pc;
            end
            if (w_accept && w_link) begin
                o_link_addr <= w_pc_plus1;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_ras_empty = w_ras_empty;
    assign o_ras_full  = w_ras_full;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_accept && w_push),
        .i_pop       (w_accept && w_pop),
        .i_push_data (w_pc_plus1),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
// ============================================================================
// Module : tb_branch_pc_unit
// Brief  : Directed bench for branch_pc_unit against an abstract model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_pc_unit;
    import branch_pkg::*;

    localparam int RAS_DEPTH    = 4;
    localparam int FLUSH_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall;
    logic [3:0]  op;
    logic [31:0] rs_a, rs_b;
    logic [15:0] offset;
    logic [25:0] target;
    logic        in_ready, redirect, link_valid, ras_empty, ras_full, ras_underflow;
    logic [31:0] pc, link_addr;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc, m_link_addr;
    bit          m_redirect, m_link_valid, m_uflow;
    int          m_flush;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    branch_pc_unit #(
        .XLEN(32), .OFF_W(16), .TGT_W(26), .RAS_DEPTH(RAS_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_PC(32'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_rs_a(rs_a), .i_rs_b(rs_b), .i_offset(offset),
        .i_target(target), .i_stall(stall), .o_pc(pc), .o_redirect(redirect),
        .o_link_valid(link_valid), .o_link_addr(link_addr),
        .o_ras_empty(ras_empty), .o_ras_full(ras_full),
        .o_ras_underflow(ras_underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_link_addr = 32'd0; m_flush = 0;
        m_redirect = 0; m_link_valid = 0; m_uflow = 0;
        m_ras.delete();
    endtask

    // Architectural model: pc as a number, RAS as a bounded queue.
    task automatic model_edge();
        bit                 acc, tk;
        logic [31:0]        nxt;
        logic signed [31:0] sa, sb, so, st;
        if (!rst_n) return;
        acc = in_valid && (m_flush == 0) && !stall;
        m_redirect = 0; m_link_valid = 0; m_uflow = 0;
        if (m_flush > 0) m_flush--;
        if (!acc) return;
        sa = rs_a; sb = rs_b;
        so = {offset, 16'b0}; so = so >>> 16;
        st = {target, 6'b0};  st = st >>> 6;
        tk = 0; nxt = m_pc + 1;
        case (op)
            OP_BEQ:  tk = (sa == sb);
            OP_BNE:  tk = (sa != sb);
            OP_BGT:  tk = (sa >  sb);
            OP_BGTE: tk = (sa >= sb);
            OP_BLT:  tk = (sa <  sb);
            OP_BLE:  tk = (sa <= sb);
            default: ;
        endcase
        if (tk) nxt = m_pc + so + 1;
        case (op)
            OP_J:  begin tk = 1; nxt = st; end
            OP_JAL: begin
                tk = 1; nxt = st;
                m_ras.push_back(m_pc + 1);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                m_link_valid = 1; m_link_addr = m_pc + 1;
            end
            OP_JR: begin tk = 1; nxt = rs_a; end
            OP_RET: begin
                tk = 1;
                if (m_ras.size() > 0) nxt = m_ras.pop_back();
                else begin nxt = rs_a; m_uflow = 1; end
            end
            default: ;
        endcase
        if (tk) begin m_redirect = 1; m_flush = FLUSH_CYCLES; end
        m_pc = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] off, input logic [25:0] tgt);
        bit will;
        bit done = 0;
        op = o; rs_a = a; rs_b = b; offset = off; target = tgt; in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            will = (m_flush == 0) && !stall;
            tick();
            done = will;
        end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",            pc,                    m_pc);
            chk("redirect",      32'(redirect),         32'(m_redirect));
            chk("link_valid",    32'(link_valid),       32'(m_link_valid));
            chk("link_addr",     link_addr,             m_link_addr);
            chk("ras_underflow", 32'(ras_underflow),    32'(m_uflow));
            chk("ras_empty",     32'(ras_empty),        32'(m_ras.size() == 0));
            chk("ras_full",      32'(ras_full),         32'(m_ras.size() == RAS_DEPTH));
            chk("in_ready",      32'(in_ready),         32'((m_flush == 0) && !stall));
        end
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; stall = 1'b0; op = OP_NOP;
        rs_a = '0; rs_b = '0; offset = '0; target = '0;
        #2 rst_n = 1'b0;
        model_reset();
        tick(); tick();
        chk_en = 1'b1;
        chk("lit_reset_pc", pc, 32'd0);
        chk("lit_reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Sequential NOPs
        repeat (3) send(OP_NOP, 0, 0, 0, 0);
        chk("lit_nop_pc", pc, 32'd3);

        // Signed branch taken with negative offset, then not taken
        send(OP_J, 0, 0, 0, 26'd10);
        send(OP_BGT, -32'sd1, -32'sd5, 16'hFFFC, 0);
        chk("lit_bgt_taken_pc", pc, 32'd7);
        chk("lit_bgt_redirect", 32'(redirect), 32'd1);
        chk("lit_bgt_ready", 32'(in_ready), 32'd0);
        send(OP_J, 0, 0, 0, 26'd10);
        send(OP_BGT, -32'sd5, -32'sd1, 16'hFFFC, 0);
        chk("lit_bgt_nt_pc", pc, 32'd11);
        chk("lit_bgt_nt_redir", 32'(redirect), 32'd0);

        // Other compares and an illegal op
        send(OP_BEQ, 32'd3, 32'd3, 16'd5, 0);
        chk("lit_beq_pc", pc, 32'd17);
        send(OP_BNE, 32'd3, 32'd3, 16'd5, 0);
        send(OP_BGTE, -32'sd2, -32'sd2, 16'd2, 0);
        send(OP_BLT, 32'h8000_0000, 32'd1, 16'd1, 0);
        send(OP_BLE, 32'd9, 32'd8, 16'd1, 0);
        send(4'd13, 0, 0, 0, 0);
        send(OP_JR, 32'h1234, 0, 0, 0);
        chk("lit_jr_pc", pc, 32'h1234);

        // JAL / RET pair
        send(OP_J, 0, 0, 0, 26'd20);
        send(OP_JAL, 0, 0, 0, 26'd100);
        chk("lit_jal_pc", pc, 32'd100);
        chk("lit_jal_link", link_addr, 32'd21);
        send(OP_RET, 0, 0, 0, 0);
        chk("lit_ret_pc", pc, 32'd21);
        chk("lit_ret_empty", 32'(ras_empty), 32'd1);

        // RAS overflow then underflow
        send(OP_J, 0, 0, 0, 26'd0);
        for (int i = 0; i < 5; i++) send(OP_JAL, 0, 0, 0, 26'(i + 1));
        chk("lit_ras_full", 32'(ras_full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(OP_RET, 0, 0, 0, 0);
            chk("lit_ret_seq", pc, 32'(5 - i));
        end
        send(OP_RET, 32'd77, 0, 0, 0);
        chk("lit_uflow_pc", pc, 32'd77);
        chk("lit_uflow_pulse", 32'(ras_underflow), 32'd1);

        // PC wrap
        send(OP_J, 0, 0, 0, 26'h3FF_FFFF);
        chk("lit_sext_tgt", pc, 32'hFFFF_FFFF);
        send(OP_NOP, 0, 0, 0, 0);
        chk("lit_wrap_pc", pc, 32'd0);

        // Stall in RUN blocks acceptance; stall across a flush
        stall = 1'b1; in_valid = 1'b1; op = OP_NOP;
        tick(); tick(); tick();
        chk("lit_stall_hold", pc, 32'd0);
        stall = 1'b0;
        tick();
        in_valid = 1'b0;
        send(OP_JR, 32'd40, 0, 0, 0);
        stall = 1'b1;
        tick(); tick();
        stall = 1'b0;
        send(OP_NOP, 0, 0, 0, 0);

        // Reset during flush with a populated RAS
        send(OP_JAL, 0, 0, 0, 26'd60);
        send(OP_JAL, 0, 0, 0, 26'd70);
        rst_n = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("lit_rst_pc", pc, 32'd0);
        chk("lit_rst_ready", 32'(in_ready), 32'd1);
        chk("lit_rst_empty", 32'(ras_empty), 32'd1);
        send(OP_NOP, 0, 0, 0, 0);
        tick(); tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
